// File: rtl/pool_pkg.sv
// Shared definitions for the max-pooling controller.
//   THERMO_W : width of a thermometer-coded pixel (values 0..15)
//   ONEHOT_W : width of the one-hot pooled result
//   state_t  : controller phase, top row vs bottom row of a window pair
package pool_pkg;
  localparam int THERMO_W = 15;
  localparam int ONEHOT_W = 16;

  typedef enum logic {
    FILL_TOP,
    FILL_BOT
  } state_t;
endpackage

// File: rtl/pool_max_ctrl_if.sv
// Streaming bus of the pooling controller: pixel input stream, pooled
// result output stream and the synchronous frame abort.
//   master : frame source / result sink side
//   slave  : pooling controller side
interface pool_max_ctrl_if;
  import pool_pkg::*;

  logic                clear;
  logic                in_valid;
  logic                in_ready;
  logic [THERMO_W-1:0] in_thermo;
  logic                out_valid;
  logic                out_ready;
  logic [ONEHOT_W-1:0] out_onehot;
  logic                out_last;

  modport master (
    output clear, in_valid, in_thermo, out_ready,
    input  in_ready, out_valid, out_onehot, out_last
  );

  modport slave (
    input  clear, in_valid, in_thermo, out_ready,
    output in_ready, out_valid, out_onehot, out_last
  );
endinterface

// File: rtl/thermo_onehot_enc.sv
// Combinational thermometer-to-one-hot encoder.
//   thermo : thermometer code, value = number of ones (contiguous from bit 0)
//   onehot : bit k set when the value is k
module thermo_onehot_enc
  import pool_pkg::*;
(
  input  logic [THERMO_W-1:0] thermo,
  output logic [ONEHOT_W-1:0] onehot
);
  // The value is k exactly where the run of ones ends: bit k-1 set, bit k clear.
  assign onehot[0]          = ~thermo[0];
  assign onehot[ONEHOT_W-1] = thermo[THERMO_W-1];

  genvar gi;
  for (gi = 1; gi < THERMO_W; gi++) begin : g_bit
    assign onehot[gi] = thermo[gi-1] & ~thermo[gi];
  end
endmodule

// File: rtl/pool_max_ctrl.sv
// Streaming 2x2 / stride-2 max-pooling controller.
// Pixels arrive row-major; the top row of each window pair is folded into a
// per-window partial maximum, the bottom row completes the window and the
// result is encoded one-hot into a one-deep registered output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of pool_max_ctrl_if (clear, pixel in, result out)
module pool_max_ctrl
  import pool_pkg::*;
#(
  parameter int IMG_W = 4,
  parameter int IMG_H = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  pool_max_ctrl_if.slave bus
);
  localparam int HALF_W = IMG_W / 2;
  localparam int PW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
  localparam int RW     = $clog2(IMG_H);
  localparam logic [PW-1:0] PAIR_LAST = PW'(HALF_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);

  // Column is tracked as (window pair index, odd half) so the partial-max
  // index is simply pair_reg.
  state_t              state_reg;
  logic [PW-1:0]       pair_reg;
  logic                odd_reg;
  logic [RW-1:0]       row_reg;
  logic [THERMO_W-1:0] bot_reg;
  logic                out_valid_reg;
  logic                out_last_reg;
  logic [ONEHOT_W-1:0] out_onehot_reg;

  logic [HALF_W*THERMO_W-1:0] part_flat;
  logic [THERMO_W-1:0]        part_sel;
  logic [THERMO_W-1:0]        win_max;
  logic [ONEHOT_W-1:0]        win_onehot;
  logic                       in_ready;
  logic                       acc;
  logic                       col_last;

  // Stalled output blocks every pixel; clear blocks intake so it always wins.
  assign in_ready = ~bus.clear & (~out_valid_reg | bus.out_ready);
  assign acc      = bus.in_valid & in_ready;
  assign col_last = odd_reg & (pair_reg == PAIR_LAST);

  genvar gi;
  for (gi = 0; gi < HALF_W; gi++) begin : g_part
    logic [THERMO_W-1:0] part_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        part_reg <= '0;
      end else if (acc && state_reg == FILL_TOP && pair_reg == PW'(gi)) begin
        part_reg <= odd_reg ? (part_reg | bus.in_thermo) : bus.in_thermo;
      end
    end
    assign part_flat[gi*THERMO_W +: THERMO_W] = part_reg;
  end

  always_comb begin
    part_sel = '0;
    for (int i = 0; i < HALF_W; i++) begin
      if (pair_reg == PW'(i)) part_sel = part_flat[i*THERMO_W +: THERMO_W];
    end
  end

  // OR of legal thermometer codes is their maximum.
  assign win_max = part_sel | bot_reg | bus.in_thermo;

  thermo_onehot_enc u_enc (
    .thermo (win_max),
    .onehot (win_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= FILL_TOP;
      pair_reg       <= '0;
      odd_reg        <= 1'b0;
      row_reg        <= '0;
      bot_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_onehot_reg <= ONEHOT_W'(1);
    end else if (bus.clear) begin
      state_reg     <= FILL_TOP;
      pair_reg      <= '0;
      odd_reg       <= 1'b0;
      row_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
    end else begin
      if (out_valid_reg && bus.out_ready) out_valid_reg <= 1'b0;

      if (acc) begin
        // Window completion; a load in the same cycle as a drain wins.
        if (state_reg == FILL_BOT) begin
          if (!odd_reg) begin
            bot_reg <= bus.in_thermo;
          end else begin
            out_valid_reg  <= 1'b1;
            out_onehot_reg <= win_onehot;
            out_last_reg   <= (row_reg == ROW_LAST) && (pair_reg == PAIR_LAST);
          end
        end

        if (!odd_reg) begin
          odd_reg <= 1'b1;
        end else begin
          odd_reg <= 1'b0;
          if (col_last) begin
            pair_reg  <= '0;
            row_reg   <= (row_reg == ROW_LAST) ? '0 : row_reg + RW'(1);
            state_reg <= (state_reg == FILL_TOP) ? FILL_BOT : FILL_TOP;
          end else begin
            pair_reg <= pair_reg + PW'(1);
          end
        end
      end
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_reg;
  assign bus.out_onehot = out_onehot_reg;
  assign bus.out_last   = out_last_reg;
endmodule

// File: tb/tb_pool_max_ctrl.sv
// Self-checking bench for pool_max_ctrl: directed frames plus randomized
// traffic checked against a frame-buffer reference model.
module tb_pool_max_ctrl;
  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pool_max_ctrl_if bus ();

  pool_max_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] oh;
    logic        last;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          frame[N];
  int          pos;
  int          cyc;
  int          n_res;
  bit          strict_lat;
  bit          acc_seen;
  int          pix[$];
  logic [15:0] got_log[$];
  logic [15:0] ramp_exp[4] = '{16'h0020, 16'h0080, 16'h2000, 16'h8000};
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [14:0] thermo(input int v);
    logic [15:0] t;
    t = (16'd1 << v) - 16'd1;
    return t[14:0];
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Reference model: store the accepted pixel; at the bottom-right pixel of a
  // window, the result is the largest of its four stored pixels.
  task automatic model_accept(input int v);
    exp_t e;
    int   r;
    int   c;
    int   m;
    frame[pos] = v;
    r = pos / W;
    c = pos % W;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      m = max2(max2(frame[(r-1)*W + c-1], frame[(r-1)*W + c]),
               max2(frame[r*W + c-1], frame[r*W + c]));
      e.oh   = 16'd1 << m;
      e.last = (pos == N - 1);
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
    pos = (pos + 1) % N;
  endtask

  task automatic model_reset();
    exp_q.delete();
    pos = 0;
  endtask

  // One clock: observe at the falling edge, update the model, then return
  // just after the rising edge so the caller can drive the next inputs.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    acc_seen = 1'b0;
    if (bus.clear) begin
      check("clear_in_ready", bus.in_ready, 0);
      model_reset();
    end else begin
      check("out_valid", bus.out_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) check("out_onehot", bus.out_onehot, exp_q[0].oh);
      if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_last", bus.out_last, e.last);
        if (strict_lat) check("latency", cyc - e.cyc, 1);
        got_log.push_back(bus.out_onehot);
        n_res++;
        $display("result %0d: onehot=%h last=%0b", n_res, bus.out_onehot, bus.out_last);
      end
      if (bus.in_valid && bus.in_ready) begin
        acc_seen = 1'b1;
        model_accept($countones(bus.in_thermo));
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run_feed(input bit rnd_valid, input bit rnd_ready);
    int budget;
    budget = 4000;
    while (pix.size() != 0 && budget > 0) begin
      bus.in_valid  = rnd_valid ? ($urandom_range(0, 9) < 7) : 1'b1;
      bus.in_thermo = thermo(pix[0]);
      if (rnd_ready) bus.out_ready = ($urandom_range(0, 9) < 7);
      cycle();
      if (acc_seen) void'(pix.pop_front());
      budget--;
    end
    bus.in_valid = 1'b0;
    check("feed_timeout", pix.size(), 0);
    pix.delete();
  endtask

  task automatic drain();
    int budget;
    budget = 20;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    while (exp_q.size() != 0 && budget > 0) begin
      cycle();
      budget--;
    end
    cycle();
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic push_ramp();
    for (int i = 0; i < N; i++) pix.push_back(i % 16);
  endtask

  task automatic check_ramp(input string tag);
    check({tag, "_count"}, got_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_log.size()) check(tag, got_log[i], ramp_exp[i]);
    end
  endtask

  initial begin
    int   budget;
    logic [15:0] held;
    int   bnd[N] = '{0, 0, 15, 0,  0, 0, 0, 0,  0, 0, 7, 0,  0, 3, 0, 0};

    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_thermo = '0;
    bus.out_ready = 1'b1;
    cyc = 0;
    n_res = 0;
    strict_lat = 1'b0;
    model_reset();

    // Power-on reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_onehot", bus.out_onehot, 16'h0001);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_last", bus.out_last, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Mid-frame reset with a result pending in the output register
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) pix.push_back(i);
    run_feed(1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("arst_out_valid", bus.out_valid, 0);
    check("arst_out_onehot", bus.out_onehot, 16'h0001);
    check("arst_in_ready", bus.in_ready, 1);
    check("arst_out_last", bus.out_last, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Ramp frame, full rate, exact latency
    bus.out_ready = 1'b1;
    strict_lat = 1'b1;
    got_log.delete();
    push_ramp();
    run_feed(1'b0, 1'b0);
    drain();
    strict_lat = 1'b0;
    check_ramp("ramp");

    // Boundary windows: {0,0,0,0}, {15,0,0,0}, {0,0,0,3}, {7,0,0,0}
    got_log.delete();
    for (int i = 0; i < N; i++) pix.push_back(bnd[i]);
    run_feed(1'b0, 1'b0);
    drain();
    check("bnd_count", got_log.size(), 4);
    if (got_log.size() == 4) begin
      check("bnd_zero", got_log[0], 16'h0001);
      check("bnd_fifteen", got_log[1], 16'h8000);
      check("bnd_three", got_log[2], 16'h0008);
      check("bnd_seven", got_log[3], 16'h0080);
    end

    // Backpressure: stall after the first result for 10 cycles
    got_log.delete();
    push_ramp();
    bus.out_ready = 1'b0;
    budget = 100;
    while (!bus.out_valid && budget > 0 && pix.size() != 0) begin
      bus.in_valid  = 1'b1;
      bus.in_thermo = thermo(pix[0]);
      cycle();
      if (acc_seen) void'(pix.pop_front());
      budget--;
    end
    check("bp_first_valid", bus.out_valid, 1);
    held = bus.out_onehot;
    bus.in_valid  = 1'b1;
    bus.in_thermo = thermo(pix.size() != 0 ? pix[0] : 0);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_hold", bus.out_onehot, held);
    end
    bus.out_ready = 1'b1;
    run_feed(1'b0, 1'b0);
    drain();
    check_ramp("bp");

    // Clear with a pixel offered at index 9
    for (int i = 0; i < 9; i++) pix.push_back(i);
    run_feed(1'b0, 1'b0);
    bus.clear     = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_thermo = thermo(9);
    cycle();
    bus.clear    = 1'b0;
    bus.in_valid = 1'b0;
    cycle();
    check("clr_out_valid", bus.out_valid, 0);
    got_log.delete();
    push_ramp();
    run_feed(1'b0, 1'b0);
    drain();
    check_ramp("clr");

    // Back-to-back random frames with random gaps on both sides
    got_log.delete();
    for (int i = 0; i < 4 * N; i++) pix.push_back($urandom_range(0, 15));
    run_feed(1'b1, 1'b1);
    drain();
    check("rand_count", got_log.size(), 16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/pool_max_ctrl.md
# pool_max_ctrl

Streaming 2x2/stride-2 max-pooling controller for the pooling filter. It accepts a row-major frame of thermometer-coded pixels and keeps per-column partial maxima for the top row of each window pair. Each completed window maximum goes through the thermometer-to-one-hot encoder sub-module and is presented on a one-deep registered output with a valid/ready handshake.

## Interface
Parameters:
- IMG_W, 4, frame width in pixels; even, ≥2
- IMG_H, 4, frame height in pixels; even, ≥2

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous frame abort
- in_valid  input  1  pixel present
- in_ready  output  1  pixel accepted when in_valid & in_ready
- in_thermo  input  15  thermometer pixel, value = number of ones (0..15)
- out_valid  output  1  pooled result present
- out_ready  input  1  downstream accepts result
- out_onehot  output  16  pooled max, one-hot (bit k ⇔ value k)
- out_last  output  1  result is the final window of the frame

## Operation
- Accepted pixel ("acc") occurs when in_valid & in_ready. Only acc advances counters.
- Counters: col 0..IMG_W-1 and row 0..IMG_H-1. col wraps to 0 and row increments at col=IMG_W-1. Both wrap to 0 after the last pixel, and the next frame starts immediately.
- State FILL_TOP (row even) on acc:
  - col even: part[col/2] := px
  - col odd: part[col/2] := part[col/2] | px
  - At col=IMG_W-1 → FILL_BOT.
- State FILL_BOT (row odd) on acc:
  - col even: bot := px
  - col odd: window max = part[col/2] | bot | px; load it into the output register; out_last := (row=IMG_H-1 & col=IMG_W-1).
  - At col=IMG_W-1 → FILL_TOP.
- Max arithmetic: bitwise OR of thermometer codes. This is exact for legal codes, and illegal input codes are outside the contract.
- Encoder: all-zero → bit 0; all-ones → bit 15; k ones → bit k.
- Output register is one deep:
  - in_ready = !out_valid | out_ready.
  - This is combinational from out_ready, with no input-to-output combinational path on data.
- clear:
  - Returns col, row, FSM to FILL_TOP/0 and drops out_valid and out_last.
  - part[] contents are don't-care.
  - clear overrides a simultaneous acc (pixel discarded) and a simultaneous output handshake.
  - in_ready is forced 0 while clear=1.

## Timing
- Reset values:
  - out_valid=0, out_last=0, out_onehot=16'h0001, in_ready=1
  - state FILL_TOP, col=row=0, bot=0, part[]=0
- Latency: out_valid rises the cycle after acc of the bottom-right pixel of a window.
- Output holds out_onehot/out_last stable while out_valid & !out_ready.
- out_valid falls after an out_ready handshake unless a new result loads in the same cycle. Simultaneous load and drain gives back-to-back results at full rate.
- Stalled output (out_valid & !out_ready) deasserts in_ready. This blocks all pixels, including top-row pixels, for simple verification.
- Throughput: one pixel per cycle sustained when out_ready=1.
- Async reset mid-frame discards everything. The first pixel after rst_n rises is pixel (0,0).

## Structure
- Shared package pool_pkg holds:
  - THERMO_W=15, ONEHOT_W=16
  - FSM state enum {FILL_TOP, FILL_BOT}
- Sub-module thermo_onehot_enc (combinational, 15→16) instantiated between the window-max OR and the output register.
- part[] is a register array of IMG_W/2 × 15 bits; no RAM.

## Test plan
- Reset: assert rst_n=0 mid-frame → out_valid=0, out_onehot=16'h0001, in_ready=1. Then feed 16 pixels → results align to pixel (0,0).
- 4x4 frame with pixel value = (row*4+col) mod 16, out_ready=1:
  - Outputs are one-hot of 5, 7, 13, 15.
  - out_last=1 only on the 4th output.
  - Each output appears one cycle after pixels 5, 7, 13, 15 are accepted.
- Boundary values: window {0,0,0,0} → 16'h0001; window {15,0,0,0} → 16'h8000; window {0,0,0,3} → 16'h0008.
- Backpressure: hold out_ready=0 after the first result → in_ready=0 and out_onehot stable for 10 cycles. Release → stream resumes, no pixel lost, results identical to the unstalled run.
- clear asserted with in_valid=1 at pixel 9 → pixel dropped, out_valid=0. A fresh 16-pixel frame then yields the correct 4 results.
- Back-to-back frames with random in_valid/out_ready gaps (≥3 frames) → results match the reference model, with out_last on every 4th result.
